uart_rx_controller: RTL and testbench

Sequencing and buffering controller for the UART receive datapath. Generates the oversample tick, synchronizes the raw RX pin, gates the receiver on/off safely at frame boundaries, and buffers received bytes in a small FIFO with a valid/ready interface toward the bus side. Sits between the pad and the system interconnect, wrapping one receiver instance's control ports.

---
 rtl/definitions_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_controller.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// definitions_pkg
// Shared constants and types for the UART receive path.
//   ctrl_state_t    : receive controller states
//   OVERSAMPLE_RATE : oversample ticks per bit; also the idle-line qualification length
//   HOLD_TIME       : receiver-side hold constant shared through this package
//   RX_FIFO_DEPTH   : default depth of the controller's receive FIFO
package definitions_pkg;

  localparam int OVERSAMPLE_RATE = 16;
  localparam int HOLD_TIME       = 2;
  localparam int RX_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    WAIT_IDLE = 2'd1,
    ACTIVE    = 2'd2,
    STOPPING  = 2'd3
  } ctrl_state_t;

  // The receiver is live (enabled, results accepted) in ACTIVE and STOPPING.
  function automatic logic is_rcv_on(input ctrl_state_t s);
    return (s == ACTIVE) || (s == STOPPING);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Circular receive buffer with head-of-RAM read.
//   clk, rstN : clock, asynchronous active-low reset
//   push      : write wdata; accepted when not full, or when full with a pop
//   pop       : remove the head; ignored while empty
//   wdata     : byte to write
//   rdata     : current head byte, 0 while empty
//   full      : DEPTH entries held
//   empty     : no entries held
module uart_rx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits and wrap on their own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; rdata is forced to 0 while empty,
  // so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller
// Sequencing and buffering around one UART receiver instance.
//   clk, rstN    : clock, asynchronous active-low reset
//   cfg_en       : receive enable request
//   cfg_div      : clocks per oversample tick (0 behaves as 1)
//   clr_status   : pulse clearing overrun / frame_err
//   rx_pin       : raw asynchronous serial line
//   rx_line      : synchronized line to the receiver
//   s_tick       : oversample tick to the receiver
//   rcv_enabled  : receiver enable
//   rcv_busy/done/err/data : receiver status and result
//   m_valid/m_data/m_ready : bus-side FIFO head handshake
//   overrun      : sticky, a byte was dropped on a full FIFO
//   frame_err    : sticky, receiver reported an error
//   ctrl_active  : controller is ACTIVE or STOPPING
module uart_rx_controller
  import definitions_pkg::*;
#(
  parameter int FIFO_DEPTH = RX_FIFO_DEPTH,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             clr_status,
  input  logic             rx_pin,
  output logic             rx_line,
  output logic             s_tick,
  output logic             rcv_enabled,
  input  logic             rcv_busy,
  input  logic             rcv_done,
  input  logic             rcv_err,
  input  logic [7:0]       rcv_data,
  output logic             m_valid,
  output logic [7:0]       m_data,
  input  logic             m_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             ctrl_active
);

  localparam int                IDLE_W    = $clog2(OVERSAMPLE_RATE);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(OVERSAMPLE_RATE - 1);

  ctrl_state_t      state;
  logic             rcv_on;
  logic             sync_q;
  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_eff;
  logic [IDLE_W-1:0] idle_cnt;
  logic             push_req;
  logic             err_evt;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign rcv_on = is_rcv_on(state);

  // Two-flop synchronizer; idle-high reset so the line never looks like a start bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q  <= 1'b1;
      rx_line <= 1'b1;
    end else begin
      sync_q  <= rx_pin;
      rx_line <= sync_q;
    end
  end

  // Tick generator. The divisor is latched at each wrap (and continuously while
  // disabled) so a cfg_div change never truncates a tick period in flight.
  assign div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tick_cnt <= '0;
      div_lat  <= DIV_W'(1);
      s_tick   <= 1'b0;
    end else if (state == DISABLED) begin
      tick_cnt <= '0;
      div_lat  <= div_eff;
      s_tick   <= 1'b0;
    end else if (tick_cnt == div_lat - DIV_W'(1)) begin
      tick_cnt <= '0;
      div_lat  <= div_eff;
      s_tick   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      s_tick   <= 1'b0;
    end
  end

  // Control FSM. Enable outputs follow the state register one cycle later.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= DISABLED;
      idle_cnt    <= '0;
      rcv_enabled <= 1'b0;
      ctrl_active <= 1'b0;
    end else begin
      rcv_enabled <= rcv_on;
      ctrl_active <= rcv_on;
      case (state)
        DISABLED: begin
          if (cfg_en) begin
            idle_cnt <= '0;
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // Require a full bit time of idle line so we never start mid-frame.
          if (!cfg_en) begin
            state <= DISABLED;
          end else if (s_tick) begin
            if (!rx_line)                   idle_cnt <= '0;
            else if (idle_cnt == IDLE_LAST) state    <= ACTIVE;
            else                            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (!cfg_en) state <= rcv_busy ? STOPPING : DISABLED;
        end
        STOPPING: begin
          if (cfg_en)                                state <= ACTIVE;
          else if (rcv_done || rcv_err || !rcv_busy) state <= DISABLED;
        end
        default: state <= DISABLED;
      endcase
    end
  end

  // Receiver results count only while the receiver is live.
  assign push_req = rcv_done & rcv_on;
  assign err_evt  = rcv_err & rcv_on;
  assign pop      = m_valid & m_ready;
  assign m_valid  = ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (push_req),
    .pop   (pop),
    .wdata (rcv_data),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky flags; a set event in the same cycle as clr_status wins.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (push_req & fifo_full & ~pop) | (overrun & ~clr_status);
      frame_err <= err_evt | (frame_err & ~clr_status);
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller
// Directed scenarios with literal expectations, followed by randomized episodes,
// all compared every cycle against a transaction-level model of the controller.
module tb_uart_rx_controller;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int OSR   = 16;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             cfg_en = 1'b0;
  logic [DIV_W-1:0] cfg_div = 16'd3;
  logic             clr_status = 1'b0;
  logic             rx_pin = 1'b1;
  logic             rcv_busy = 1'b0;
  logic             rcv_done = 1'b0;
  logic             rcv_err = 1'b0;
  logic [7:0]       rcv_data = 8'h00;
  logic             m_ready = 1'b0;
  logic             rx_line, s_tick, rcv_enabled, m_valid, overrun, frame_err, ctrl_active;
  logic [7:0]       m_data;

  uart_rx_controller #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rstN(rstN), .cfg_en(cfg_en), .cfg_div(cfg_div), .clr_status(clr_status),
    .rx_pin(rx_pin), .rx_line(rx_line), .s_tick(s_tick), .rcv_enabled(rcv_enabled),
    .rcv_busy(rcv_busy), .rcv_done(rcv_done), .rcv_err(rcv_err), .rcv_data(rcv_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .overrun(overrun),
    .frame_err(frame_err), .ctrl_active(ctrl_active)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_DIS, M_WAIT, M_ACT, M_STOP} mstate_t;
  mstate_t    ms = M_DIS;
  int         idle_run = 0;   // consecutive high ticks seen while waiting
  int         run_cyc = 0;    // cycles the tick generator has been running
  bit         mtick = 1'b0, ml1 = 1'b1, ml2 = 1'b1, men = 1'b0, mov = 1'b0, mfe = 1'b0;
  logic [7:0] q[$];

  function automatic int eff_div();
    return (cfg_div == 0) ? 1 : int'(cfg_div);
  endfunction

  initial forever begin
    @(posedge clk or negedge rstN);
    if (!rstN) begin
      ms = M_DIS; idle_run = 0; run_cyc = 0;
      mtick = 0; ml1 = 1; ml2 = 1; men = 0; mov = 0; mfe = 0;
      q.delete();
    end else begin
      mstate_t st_old;
      bit      live, tick_old, line_old, do_pop, ov_set;
      st_old   = ms;
      live     = (ms == M_ACT) || (ms == M_STOP);
      tick_old = mtick;
      line_old = ml2;
      case (ms)
        M_DIS:  if (cfg_en) begin ms = M_WAIT; idle_run = 0; end
        M_WAIT: if (!cfg_en) ms = M_DIS;
                else if (tick_old) begin
                  idle_run = line_old ? idle_run + 1 : 0;
                  if (idle_run == OSR) ms = M_ACT;
                end
        M_ACT:  if (!cfg_en) ms = rcv_busy ? M_STOP : M_DIS;
        M_STOP: if (cfg_en) ms = M_ACT;
                else if (rcv_done || rcv_err || !rcv_busy) ms = M_DIS;
        default: ms = M_DIS;
      endcase
      // A tick is due every eff_div() cycles of running.
      if (st_old != M_DIS) begin
        run_cyc++;
        mtick = (run_cyc % eff_div()) == 0;
      end else begin
        run_cyc = 0;
        mtick = 0;
      end
      ml2 = ml1;
      ml1 = rx_pin;
      do_pop = (q.size() > 0) && m_ready;
      if (do_pop) void'(q.pop_front());
      ov_set = 0;
      if (rcv_done && live) begin
        if (q.size() < DEPTH) q.push_back(rcv_data);
        else ov_set = 1;
      end
      mov = ov_set || (mov && !clr_status);
      mfe = (rcv_err && live) || (mfe && !clr_status);
      men = live;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("rx_line", rx_line, ml2);
    check("s_tick", s_tick, mtick);
    check("rcv_enabled", rcv_enabled, men);
    check("ctrl_active", ctrl_active, men);
    check("m_valid", m_valid, q.size() > 0);
    check("m_data", m_data, (q.size() > 0) ? q[0] : 8'h00);
    check("overrun", overrun, mov);
    check("frame_err", frame_err, mfe);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_done(input logic [7:0] d);
    rcv_done = 1'b1; rcv_data = d;
    step();
    rcv_done = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, m_data, exp);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic wait_enabled();
    int t = 0;
    while (!rcv_enabled && t < 400) begin step(); t++; end
    check("enable_timeout", rcv_enabled, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_line"}, rx_line, 1'b1);
    check({tag, "_s_tick"}, s_tick, 1'b0);
    check({tag, "_rcv_enabled"}, rcv_enabled, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, 8'h00);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_ctrl_active"}, ctrl_active, 1'b0);
  endtask

  logic [7:0] exp_first[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_second[4] = '{8'h02, 8'h03, 8'h04, 8'h05};

  initial begin
    bit any_tick;

    // Reset values.
    repeat (2) step();
    check_reset_outputs("reset");
    #2 rstN = 1'b1;
    step();

    // cfg_div=3 on an idle line: tick every 3rd cycle, enable after 16 ticks.
    cfg_div = 16'd3; cfg_en = 1'b1;
    for (int i = 1; i <= 51; i++) begin
      step();
      if (i <= 7) check("tick_period", s_tick, (i > 1) && ((i - 1) % 3 == 0));
      if (i == 50) check("enable_not_yet", rcv_enabled, 1'b0);
      if (i == 51) check("enable_after_16_ticks", rcv_enabled, 1'b1);
    end

    // Line held low while waiting: no enable; release and enable follows 16 ticks.
    cfg_en = 1'b0;
    repeat (3) step();
    rx_pin = 1'b0; cfg_div = 16'd1; cfg_en = 1'b1;
    repeat (60) step();
    check("held_low_no_enable", rcv_enabled, 1'b0);
    rx_pin = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == 18) check("release_not_yet", rcv_enabled, 1'b0);
      if (i == 19) check("release_enable", rcv_enabled, 1'b1);
    end

    // Five bytes into a four-deep FIFO with no consumer.
    for (int b = 1; b <= 5; b++) pulse_done(8'(b * 8'h11));
    check("overrun_after_5", overrun, 1'b1);
    check("full_valid", m_valid, 1'b1);
    for (int i = 0; i < 4; i++) pop_expect("pop_order", exp_first[i]);
    check("drained", m_valid, 1'b0);

    // Full FIFO with push and pop in the same cycle: no overrun.
    clr_status = 1'b1; step(); clr_status = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    for (int b = 1; b <= 4; b++) pulse_done(8'(b));
    rcv_done = 1'b1; rcv_data = 8'h05; m_ready = 1'b1;
    step();
    rcv_done = 1'b0; m_ready = 1'b0;
    check("full_push_pop_no_overrun", overrun, 1'b0);
    for (int i = 0; i < 4; i++) pop_expect("push_pop_order", exp_second[i]);
    check("drained2", m_valid, 1'b0);

    // Disable during a frame: STOPPING until the byte completes.
    rcv_busy = 1'b1; step();
    cfg_en = 1'b0; step();
    step();
    check("stopping_active", ctrl_active, 1'b1);
    check("stopping_enabled", rcv_enabled, 1'b1);
    rcv_done = 1'b1; rcv_data = 8'hA5; rcv_busy = 1'b0;
    step();
    rcv_done = 1'b0;
    check("stop_byte_pushed", m_data, 8'hA5);
    repeat (2) step();
    check("stopped_inactive", ctrl_active, 1'b0);
    any_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); any_tick |= s_tick; end
    check("tick_stops", any_tick, 1'b0);
    pop_expect("stop_byte_pop", 8'hA5);

    // Framing error, clear, and set-vs-clear priority.
    cfg_en = 1'b1;
    wait_enabled();
    rcv_err = 1'b1; step(); rcv_err = 1'b0;
    check("frame_err_set", frame_err, 1'b1);
    check("err_no_push", m_valid, 1'b0);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    check("frame_err_cleared", frame_err, 1'b0);
    rcv_err = 1'b1; clr_status = 1'b1; step(); rcv_err = 1'b0; clr_status = 1'b0;
    check("set_beats_clear", frame_err, 1'b1);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    rcv_done = 1'b1; rcv_err = 1'b1; rcv_data = 8'h3C;
    step();
    rcv_done = 1'b0; rcv_err = 1'b0;
    check("done_err_byte", m_data, 8'h3C);
    check("done_err_flag", frame_err, 1'b1);

    // Reset mid-stream.
    rcv_busy = 1'b1; rx_pin = 1'b0;
    step();
    #2 rstN = 1'b0;
    #1 check_reset_outputs("midreset");
    step();
    rcv_busy = 1'b0; rx_pin = 1'b1; cfg_en = 1'b0;
    #2 rstN = 1'b1;

    // Randomized episodes.
    for (int ep = 0; ep < 8; ep++) begin
      int t;
      cfg_en = 1'b0; rcv_busy = 1'b0; rcv_done = 1'b0; rcv_err = 1'b0;
      clr_status = 1'b0; m_ready = 1'b1; rx_pin = 1'b1;
      t = 0;
      step();
      while (ctrl_active && t < 40) begin step(); t++; end
      check("drain_to_disabled", ctrl_active, 1'b0);
      repeat (2) step();
      cfg_div = DIV_W'($urandom_range(0, 4));
      cfg_en = 1'b1;
      for (int c = 0; c < 400; c++) begin
        step();
        rx_pin     = (c < 120) ? ($urandom_range(0, 31) != 0) : 1'b1;
        rcv_busy   = 1'($urandom_range(0, 1));
        rcv_done   = ($urandom_range(0, 3) == 0);
        rcv_err    = ($urandom_range(0, 15) == 0);
        rcv_data   = 8'($urandom);
        m_ready    = ($urandom_range(0, 2) != 0);
        clr_status = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) cfg_en = ~cfg_en;
      end
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
